// File: rtl/serial_subtractor_if.sv
// Bus bundle for the bit-serial subtractor: operand request side plus result side.
//
// Handshake: the master raises start with A/B/Bin stable. The slave accepts it
// on any rising edge where busy=0. There is no ready signal; busy=0 is the ready
// indication. A start seen while busy=1 is dropped, not queued. Once accepted,
// busy stays high for WIDTH cycles. Then done pulses for exactly one cycle, and
// Diff/Bout are valid from that cycle until the next completion or reset.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic [WIDTH-1:0] Diff;
  logic             Bout;
  logic             busy;
  logic             done;

  modport master (
    output start, A, B, Bin,
    input  Diff, Bout, busy, done
  );

  modport slave (
    input  start, A, B, Bin,
    output Diff, Bout, busy, done
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: Diff = A - B - Bin (mod 2^WIDTH), LSB first.
// A single full-subtract cell and a borrow flop are reused for WIDTH cycles.
// dbg_state exposes the FSM encoding: 0 = IDLE, 1 = SHIFT, 2 = DONE.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_subtractor_if.slave   bus,
  output logic [1:0]           dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] d_sr;
  logic             brw;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] diff_q;
  logic             bout_q;

  logic             a0;
  logic             b0;
  logic             d_bit;
  logic             brw_nxt;
  logic             accept;
  logic             last_bit;

  // One full-subtract cell on the current LSBs, plus the accept and last-bit qualifiers.
  always_comb begin
    a0       = a_sr[0];
    b0       = b_sr[0];
    d_bit    = a0 ^ b0 ^ brw;
    brw_nxt  = (~a0 & b0) | (~(a0 ^ b0) & brw);
    accept   = (state != S_SHIFT) && bus.start;
    last_bit = (cnt == CW'(WIDTH - 1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. DONE accepts a new start so back-to-back ops cost WIDTH+1 cycles.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (bus.start) state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        if (last_bit) state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = bus.start ? S_SHIFT : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, bit-serial shifting and result latch. The result stays held across new starts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      d_sr   <= '0;
      brw    <= 1'b0;
      cnt    <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else if (accept) begin
      a_sr <= bus.A;
      b_sr <= bus.B;
      brw  <= bus.Bin;
      cnt  <= '0;
    end else if (state == S_SHIFT) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      d_sr <= {d_bit, d_sr[WIDTH-1:1]};
      brw  <= brw_nxt;
      if (last_bit) begin
        cnt    <= '0;
        diff_q <= {d_bit, d_sr[WIDTH-1:1]};
        bout_q <= brw_nxt;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Status and result outputs.
  assign bus.busy  = (state == S_SHIFT);
  assign bus.done  = (state == S_DONE);
  assign bus.Diff  = diff_q;
  assign bus.Bout  = bout_q;
  assign dbg_state = state;

endmodule
